// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI command master.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    GAP   = 3'd3,
    HOLD  = 3'd4
  } spi_state_e;

  localparam int DEFAULT_CLK_DIV = 4;

  // Bits needed to count n values (0..n-1).
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_sck_divider.sv
// Half-period tick generator: counts CLK_DIV-1 down to 0, ticks at 0, reloads on load or tick.
module spi_sck_divider
  import spi_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign o_tick = i_en & (cnt_q == {CW{1'b0}});

  // Next count: load wins, otherwise count down and wrap while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = RELOAD;
    end else if (i_en) begin
      if (cnt_q == {CW{1'b0}}) begin
        cnt_d = RELOAD;
      end else begin
        cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_cmd.sv
// SPI master sending configuration words with full-duplex capture and multi-word bursts under one SS_n.
module spi_master_cmd
  import spi_pkg::*;
#(
  parameter int   WIDTH   = 8,
  parameter logic CPOL    = 1'b0,
  parameter logic CPHA    = 1'b0,
  parameter logic LSB     = 1'b0,
  parameter int   CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_tx_data,
  input  logic             i_tx_last,
  input  logic             i_tx_valid,
  output logic             o_tx_ready,
  output logic [WIDTH-1:0] o_rx_data,
  output logic             o_rx_valid,
  output logic             o_busy,
  output logic             o_sck,
  output logic             o_mosi,
  input  logic             i_miso,
  output logic             o_ss_n
);

  localparam int ECW = clog2(2 * WIDTH);

  if (CLK_DIV < 2 || WIDTH < 8 || WIDTH > 64) begin : g_param_check
    $fatal(1, "spi_master_cmd: CLK_DIV must be >= 2 and WIDTH in 8..64");
  end

  spi_state_e       state_q, state_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic [ECW-1:0]   edge_q, edge_d;
  logic             last_q, last_d;
  logic             sck_q, sck_d;
  logic             mosi_q, mosi_d;
  logic             ss_n_q, ss_n_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             rx_valid_q, rx_valid_d;
  logic             tick_s, div_load_s, div_en_s;
  logic             accept_s, shift_edge_s, last_edge_s;

  function automatic logic out_bit(input logic [WIDTH-1:0] v);
    return LSB ? v[0] : v[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v);
    return LSB ? {1'b0, v[WIDTH-1:1]} : {v[WIDTH-2:0], 1'b0};
  endfunction

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v, input logic b);
    return LSB ? {b, v[WIDTH-1:1]} : {v[WIDTH-2:0], b};
  endfunction

  assign accept_s     = i_tx_valid & ready_q;
  // Even edge index is the leading edge; CPHA selects which edge shifts.
  assign shift_edge_s = edge_q[0] ^ CPHA;
  assign last_edge_s  = (edge_q == ECW'(2 * WIDTH - 1));
  assign div_load_s   = (state_d != state_q);
  assign div_en_s     = (state_q == SETUP) | (state_q == XFER) | (state_q == HOLD);

  spi_sck_divider #(.CLK_DIV(CLK_DIV)) u_div (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (div_load_s),
    .i_en    (div_en_s),
    .o_tick  (tick_s)
  );

  // Next-state, datapath and output computation; outputs follow the next state so they stay registered.
  always_comb begin
    state_d    = state_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    edge_d     = edge_q;
    last_d     = last_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    case (state_q)
      IDLE, GAP: begin
        sck_d = CPOL;
        if (accept_s) begin
          // With CPHA=0 the first bit is already on MOSI during SETUP.
          tx_shift_d = CPHA ? i_tx_data : shift_out(i_tx_data);
          mosi_d     = CPHA ? mosi_q : out_bit(i_tx_data);
          rx_shift_d = {WIDTH{1'b0}};
          last_d     = i_tx_last;
          edge_d     = {ECW{1'b0}};
          state_d    = SETUP;
        end else begin
          state_d = state_q;
        end
      end
      SETUP: begin
        if (tick_s) begin
          state_d = XFER;
        end else begin
          state_d = SETUP;
        end
      end
      XFER: begin
        if (tick_s) begin
          sck_d = ~sck_q;
          if (shift_edge_s) begin
            mosi_d     = out_bit(tx_shift_q);
            tx_shift_d = shift_out(tx_shift_q);
          end else begin
            rx_shift_d = shift_in(rx_shift_q, i_miso);
          end
          if (last_edge_s) begin
            rx_data_d  = rx_shift_d;
            rx_valid_d = 1'b1;
            edge_d     = {ECW{1'b0}};
            state_d    = last_q ? HOLD : GAP;
          end else begin
            edge_d = edge_q + ECW'(1'b1);
          end
        end else begin
          state_d = XFER;
        end
      end
      HOLD: begin
        if (tick_s) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ss_n_d  = (state_d == IDLE);
    ready_d = (state_d == IDLE) | (state_d == GAP);
    busy_d  = (state_d != IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      tx_shift_q <= {WIDTH{1'b0}};
      rx_shift_q <= {WIDTH{1'b0}};
      rx_data_q  <= {WIDTH{1'b0}};
      rx_valid_q <= 1'b0;
      edge_q     <= {ECW{1'b0}};
      last_q     <= 1'b0;
      sck_q      <= CPOL;
      mosi_q     <= 1'b0;
      ss_n_q     <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      edge_q     <= edge_d;
      last_q     <= last_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      ss_n_q     <= ss_n_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign o_tx_ready = ready_q;
  assign o_rx_data  = rx_data_q;
  assign o_rx_valid = rx_valid_q;
  assign o_busy     = busy_q;
  assign o_sck      = sck_q;
  assign o_mosi     = mosi_q;
  assign o_ss_n     = ss_n_q;

endmodule

// File: tb/tb_spi_master_cmd.sv
// Directed bench: three master instances (mode 0 loopback, mode 3 with slave model, LSB-first loopback).
module tb_spi_master_cmd;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_last;
  logic [2:0] tx_valid;
  logic [2:0] rdy, rxv, busy, sck, mosi, ss;
  logic [7:0] rxd [3];
  logic       miso3 = 1'b0;
  logic [1:0] sel;
  logic       m_sck, m_mosi, m_ss, m_rdy, m_rxv, m_busy;
  logic [7:0] m_rxd;
  logic [7:0] cap = 8'h00;
  int         cap_n = 0;
  logic [7:0] slv_reply = 8'hC3;
  logic [7:0] slv_rx = 8'h00;
  int         slv_idx = 0;
  int         n_chk = 0;
  int         n_err = 0;

  typedef struct {
    logic [1:0] s;
    logic [7:0] data;
    logic [7:0] exp_rx;
    logic [7:0] exp_mosi;
  } vec_t;
  vec_t vecs [7];

  always #5 clk = ~clk;

  spi_master_cmd #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .LSB(1'b0), .CLK_DIV(2)) u_mode0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_data(tx_data), .i_tx_last(tx_last),
    .i_tx_valid(tx_valid[0]), .o_tx_ready(rdy[0]), .o_rx_data(rxd[0]), .o_rx_valid(rxv[0]),
    .o_busy(busy[0]), .o_sck(sck[0]), .o_mosi(mosi[0]), .i_miso(mosi[0]), .o_ss_n(ss[0]));

  spi_master_cmd #(.WIDTH(8), .CPOL(1'b1), .CPHA(1'b1), .LSB(1'b0), .CLK_DIV(2)) u_mode3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_data(tx_data), .i_tx_last(tx_last),
    .i_tx_valid(tx_valid[1]), .o_tx_ready(rdy[1]), .o_rx_data(rxd[1]), .o_rx_valid(rxv[1]),
    .o_busy(busy[1]), .o_sck(sck[1]), .o_mosi(mosi[1]), .i_miso(miso3), .o_ss_n(ss[1]));

  spi_master_cmd #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .LSB(1'b1), .CLK_DIV(2)) u_lsb (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_data(tx_data), .i_tx_last(tx_last),
    .i_tx_valid(tx_valid[2]), .o_tx_ready(rdy[2]), .o_rx_data(rxd[2]), .o_rx_valid(rxv[2]),
    .o_busy(busy[2]), .o_sck(sck[2]), .o_mosi(mosi[2]), .i_miso(mosi[2]), .o_ss_n(ss[2]));

  assign m_sck  = sck[sel];
  assign m_mosi = mosi[sel];
  assign m_ss   = ss[sel];
  assign m_rdy  = rdy[sel];
  assign m_rxv  = rxv[sel];
  assign m_busy = busy[sel];
  assign m_rxd  = rxd[sel];

  // MOSI as seen by a slave sampling on SCK rising (all three modes sample there), in arrival order.
  always @(posedge m_sck) begin
    cap   <= {cap[6:0], m_mosi};
    cap_n <= cap_n + 1;
  end

  // Mode-3 slave: drive reply MSB first on falling SCK, capture MOSI on rising SCK.
  always @(negedge sck[1] or posedge ss[1]) begin
    if (ss[1]) begin
      slv_idx <= 0;
    end else begin
      miso3   <= slv_reply[7 - slv_idx];
      slv_idx <= slv_idx + 1;
    end
  end

  always @(posedge sck[1]) begin
    if (!ss[1]) slv_rx <= {slv_rx[6:0], mosi[1]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [1:0] s, input logic [7:0] data,
                            input logic [7:0] exp_rx, input logic [7:0] exp_mosi, input string tag);
    int ss_cnt, nv, vk, start, w;
    logic [7:0] got;
    ss_cnt = 0; nv = 0; vk = 0; w = 0; got = 8'h00;
    sel = s;
    @(negedge clk);
    while (!m_rdy && w < 500) begin
      @(negedge clk);
      w++;
    end
    start = cap_n;
    tx_data = data; tx_last = 1'b1; tx_valid[s] = 1'b1;
    @(negedge clk);
    tx_valid[s] = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      if (!m_ss) ss_cnt++;
      if (m_rxv) begin
        nv++;
        if (nv == 1) begin
          vk = k;
          got = m_rxd;
        end
      end
      if (m_ss) break;
      @(negedge clk);
    end
    check({tag, "_ss_low_cycles"}, ss_cnt, 36);
    check({tag, "_rx_latency"}, vk, 35);
    check({tag, "_rx_pulses"}, nv, 1);
    check({tag, "_rx_data"}, got, exp_rx);
    check({tag, "_mosi_bits"}, cap, exp_mosi);
    check({tag, "_sck_rises"}, cap_n - start, 8);
    check({tag, "_ready_after"}, m_rdy, 1);
    check({tag, "_busy_after"}, m_busy, 0);
    check({tag, "_sck_idle"}, m_sck, (s == 2'd1) ? 1 : 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ss_cnt, nv, k1, k2, acc, acc_k, start, w, extra, gap_cycles, gap_bad;
    logic drop;
    logic [7:0] r1, r2;

    vecs[0] = '{2'd0, 8'hA5, 8'hA5, 8'hA5};
    vecs[1] = '{2'd0, 8'h00, 8'h00, 8'h00};
    vecs[2] = '{2'd0, 8'hFF, 8'hFF, 8'hFF};
    vecs[3] = '{2'd0, 8'h81, 8'h81, 8'h81};
    vecs[4] = '{2'd1, 8'h3C, 8'hC3, 8'h3C};
    vecs[5] = '{2'd2, 8'h01, 8'h01, 8'h80};
    vecs[6] = '{2'd2, 8'h0F, 8'h0F, 8'hF0};

    rst_n = 1'b0; tx_data = 8'h00; tx_last = 1'b0; tx_valid = 3'b000; sel = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_ss_n", ss[0], 1);
    check("rst_sck_mode0", sck[0], 0);
    check("rst_sck_mode3", sck[1], 1);
    check("rst_mosi", mosi[0], 0);
    check("rst_ready", rdy[0], 1);
    check("rst_busy", busy[0], 0);
    check("rst_rx_valid", rxv[0], 0);
    check("rst_rx_data", rxd[0], 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].s, vecs[i].data, vecs[i].exp_rx, vecs[i].exp_mosi, $sformatf("vec%0d", i));
      if (vecs[i].s == 2'd1) check("slave_capture", slv_rx, vecs[i].data);
    end

    // Burst: 0x12 (not last), then 0x34 (last) offered 10 cycles after the first rx pulse.
    sel = 2'd0;
    @(negedge clk);
    start = cap_n; ss_cnt = 0; nv = 0; k1 = 0; k2 = 0; gap_cycles = 0; gap_bad = 0;
    drop = 1'b0; r1 = 8'h00; r2 = 8'h00;
    tx_data = 8'h12; tx_last = 1'b0; tx_valid[0] = 1'b1;
    @(negedge clk);
    tx_valid[0] = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      if (drop) begin
        tx_valid[0] = 1'b0;
        drop = 1'b0;
      end
      if (!ss[0]) ss_cnt++;
      if (rxv[0]) begin
        nv++;
        if (nv == 1) begin k1 = k; r1 = rxd[0]; end
        else begin k2 = k; r2 = rxd[0]; end
      end
      if (k1 > 0 && k <= k1 + 10) begin
        gap_cycles++;
        if (!rdy[0] || ss[0] || sck[0]) gap_bad++;
      end
      if (k1 > 0 && k == k1 + 10) begin
        tx_data = 8'h34; tx_last = 1'b1; tx_valid[0] = 1'b1; drop = 1'b1;
      end
      if (ss[0]) break;
      @(negedge clk);
    end
    check("burst_rx_pulses", nv, 2);
    check("burst_rx1", r1, 8'h12);
    check("burst_rx2", r2, 8'h34);
    check("burst_rx1_time", k1, 35);
    check("burst_rx2_time", k2, 80);
    check("burst_ss_low_cycles", ss_cnt, 81);
    check("burst_gap_cycles", gap_cycles, 11);
    check("burst_gap_bad", gap_bad, 0);
    check("burst_mosi_last", cap, 8'h34);
    check("burst_sck_rises", cap_n - start, 16);

    // Valid held through XFER with the next word: it must wait for GAP and go out exactly once.
    @(negedge clk);
    start = cap_n; ss_cnt = 0; nv = 0; k2 = 0; acc = 0; acc_k = 0; drop = 1'b0;
    r1 = 8'h00; r2 = 8'h00;
    tx_data = 8'h11; tx_last = 1'b0; tx_valid[0] = 1'b1;
    @(negedge clk);
    tx_data = 8'h22; tx_last = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      if (drop) begin
        tx_valid[0] = 1'b0;
        drop = 1'b0;
      end
      if (!ss[0]) ss_cnt++;
      if (rxv[0]) begin
        nv++;
        if (nv == 1) r1 = rxd[0];
        else begin k2 = k; r2 = rxd[0]; end
      end
      if (tx_valid[0] && rdy[0]) begin
        acc++; acc_k = k; drop = 1'b1;
      end
      if (ss[0]) break;
      @(negedge clk);
    end
    tx_valid[0] = 1'b0;
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy[0] || rxv[0]) extra++;
    end
    check("hold_accepts", acc, 1);
    check("hold_accept_time", acc_k, 35);
    check("hold_rx_pulses", nv, 2);
    check("hold_rx1", r1, 8'h11);
    check("hold_rx2", r2, 8'h22);
    check("hold_rx2_time", k2, 70);
    check("hold_ss_low_cycles", ss_cnt, 71);
    check("hold_mosi_last", cap, 8'h22);
    check("hold_sck_rises", cap_n - start, 16);
    check("hold_no_duplicate", extra, 0);

    // Reset in the middle of XFER.
    @(negedge clk);
    start = cap_n; w = 0;
    tx_data = 8'h77; tx_last = 1'b1; tx_valid[0] = 1'b1;
    @(negedge clk);
    tx_valid[0] = 1'b0;
    while ((cap_n - start) < 4 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("midrst_busy_before", busy[0], 1);
    check("midrst_sck_before", sck[0], 1);
    rst_n = 1'b0;
    #1;
    check("midrst_ss_n", ss[0], 1);
    check("midrst_sck", sck[0], 0);
    check("midrst_busy", busy[0], 0);
    check("midrst_rx_valid", rxv[0], 0);
    nv = 0;
    repeat (3) begin
      @(negedge clk);
      if (rxv[0]) nv++;
    end
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (rxv[0] || busy[0]) nv++;
    end
    check("midrst_no_rx_after", nv, 0);
    send_frame(2'd0, 8'h5A, 8'h5A, 8'h5A, "post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
